// File: rtl/shift_reg_n.sv
// -----------------------------------------------------------------------------
// shift_reg_n
//
// Parametrised universal shift register with a multi-cycle "shift by N"
// sequencer. A single step of any operation can be executed directly from
// IDLE (en), or a shift/rotate can be repeated amt times under a busy/done
// handshake (start). Used as a serial/parallel converter and a small
// bit-manipulation engine.
//
// Operation codes (sel / latched op):
//   000 hold                    100 rotate right
//   001 load data               101 logical shift left, LSB <- 0
//   010 shift right, MSB <- rin 110 arithmetic shift right
//   011 shift left,  LSB <- lin 111 rotate left
//
// Ports:
//   clk    rising-edge clock
//   clr    synchronous active-high reset, overrides everything
//   en     execute sel once this cycle (IDLE only)
//   start  begin sequenced operation (IDLE only), priority over en
//   sel    operation code
//   amt    repeat count for a sequenced shift/rotate
//   data   parallel load value
//   rin    serial input entering the MSB on shift right
//   lin    serial input entering the LSB on shift left
//   out    register contents
//   rout   out[0]
//   lout   out[WIDTH-1]
//   busy   high while the sequencer is running
//   done   one-cycle completion pulse after a start
// -----------------------------------------------------------------------------
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data,
    input  logic             rin,
    input  logic             lin,
    output logic [WIDTH-1:0] out,
    output logic             rout,
    output logic             lout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] q_q,     q_nxt;
    logic [AMT_W-1:0] cnt_q,   cnt_nxt;
    logic [2:0]       op_q,    op_nxt;
    logic             done_q,  done_nxt;

    // One step of the selected operation applied to the current value.
    // Serial inputs are taken as they are at the executing edge, so a long
    // shift streams whatever rin/lin carry cycle by cycle.
    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             si_r,
        input logic             si_l
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = cur;
            3'b001:  r = ld;
            3'b010:  r = {si_r, cur[WIDTH-1:1]};
            3'b011:  r = {cur[WIDTH-2:0], si_l};
            3'b100:  r = {cur[0], cur[WIDTH-1:1]};
            3'b101:  r = {cur[WIDTH-2:0], 1'b0};
            3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
        endcase
        return r;
    endfunction

    // Next-state / datapath decision.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state_q;
        q_nxt     = q_q;
        cnt_nxt   = cnt_q;
        op_nxt    = op_q;
        done_nxt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (sel[2:1] == 2'b00) begin
                        // hold/load are not repeatable: execute once, amt ignored
                        q_nxt    = step(sel, q_q, data, rin, lin);
                        done_nxt = 1'b1;
                    end else if (amt == '0) begin
                        // zero-length sequence completes without touching out
                        done_nxt = 1'b1;
                    end else begin
                        // the start edge only arms the sequencer; no data change
                        op_nxt    = sel;
                        cnt_nxt   = amt;
                        state_nxt = RUN;
                    end
                end else if (en) begin
                    q_nxt = step(sel, q_q, data, rin, lin);
                end
            end

            RUN: begin
                q_nxt   = step(op_q, q_q, data, rin, lin);
                cnt_nxt = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (clr) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            q_q     <= q_nxt;
            cnt_q   <= cnt_nxt;
            op_q    <= op_nxt;
            done_q  <= done_nxt;
        end
    end

    assign out  = q_q;
    assign rout = q_q[0];
    assign lout = q_q[WIDTH-1];
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule
